// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Optional hold-grant feature is enabled by RR_MUX_LOCK_EN.
package rr_mux_pkg;

    localparam int NREQ   = 4;
    localparam int DEF_DW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_mux_pick.sv
// Round-robin winner search: first set req bit after ptr, wrapping.
// Purely combinational; any_req flags that a winner exists.
module rr_mux_pick
    import rr_mux_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      winner,
    output logic            any_req
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [1:0]        off;

    always_comb begin
        dbl = {req, req};
        // rot[0] is the requester right after ptr
        rot = NREQ'(dbl >> (3'(ptr) + 3'd1));
        off = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
        winner  = ptr + 2'd1 + off;
        any_req = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with registered data mux and select.
// Define RR_MUX_LOCK_EN to add the lock port (hold current grant).
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   c,
    input  logic [DW-1:0]   d,
    input  logic            out_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [NREQ-1:0] lock,
`endif
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] ack,
    output logic            S0,
    output logic            S1
);

    state_t          state;
    logic [1:0]      ptr;
    logic [1:0]      sel;
    logic [1:0]      pick_ptr;
    logic [1:0]      winner;
    logic [1:0]      new_g;
    logic            any_req;
    logic            xfer;
    logic            hold_lock;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   load_data;
    logic [NREQ-1:0] grant_q;

    // After a transfer the search starts just past the current grant
    assign pick_ptr = (state == BUSY) ? sel : ptr;

    rr_mux_pick u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign xfer = (state == BUSY) && out_ready;

`ifdef RR_MUX_LOCK_EN
    assign hold_lock = (state == BUSY) && lock[sel] && req[sel];
`else
    assign hold_lock = 1'b0;
`endif

    assign new_g = hold_lock ? sel : winner;

    always_comb begin
        load_data = a;
        unique case (new_g)
            2'd0: load_data = a;
            2'd1: load_data = b;
            2'd2: load_data = c;
            2'd3: load_data = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd3;
            sel     <= 2'd0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE) && any_req: begin
                    state   <= BUSY;
                    sel     <= new_g;
                    data_q  <= load_data;
                    grant_q <= NREQ'(1) << new_g;
                end
                xfer && any_req: begin
                    if (!hold_lock) ptr <= sel;
                    sel     <= new_g;
                    data_q  <= load_data;
                    grant_q <= NREQ'(1) << new_g;
                end
                xfer && !any_req: begin
                    state   <= IDLE;
                    ptr     <= sel;
                    grant_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == BUSY);
    assign out_data  = data_q;
    assign grant     = grant_q;
    assign ack       = (xfer && rst_n) ? grant_q : '0;
    assign S0        = sel[0];
    assign S1        = sel[1];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: vector table, directed corner cases, random run
// against a behavioural round-robin model.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic       out_ready;
`ifdef RR_MUX_LOCK_EN
    logic [3:0] lock;
`endif
    logic       out_valid;
    logic [3:0] out_data;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       S0, S1;

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model state
    bit     m_busy;
    int     m_ptr;
    int     m_g;
    int     m_data;

    rr_mux_arbiter #(.DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_ready (out_ready),
`ifdef RR_MUX_LOCK_EN
        .lock      (lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .grant     (grant),
        .ack       (ack),
        .S0        (S0),
        .S1        (S1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] a, b, c, d;
        logic       rdy;
        logic       ev;
        logic [3:0] ed;
        logic [3:0] eg;
        logic [3:0] ea;
        logic [1:0] es;
    } vec_t;

    vec_t tbl[13];

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] vc, input logic [3:0] vd,
                         input logic rdy, input logic [3:0] lk);
        rst_n = r;
        req = rq;
        a = va;
        b = vb;
        c = vc;
        d = vd;
        out_ready = rdy;
`ifdef RR_MUX_LOCK_EN
        lock = lk;
`else
        if (lk != 4'd0) $display("note: lock ignored in this build");
`endif
    endtask

    function automatic int rr_next(input int base);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (base + k) % 4;
            if (req[idx]) return idx;
        end
        return base;
    endfunction

    function automatic int dsel(input int g);
        case (g)
            0: return int'(a);
            1: return int'(b);
            2: return int'(c);
            default: return int'(d);
        endcase
    endfunction

    task automatic model_edge();
        bit locked;
        locked = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr = 3;
            m_g = 0;
            m_data = 0;
        end else if (!m_busy) begin
            if (req != 4'd0) begin
                m_g = rr_next(m_ptr);
                m_busy = 1'b1;
                m_data = dsel(m_g);
            end
        end else if (out_ready) begin
`ifdef RR_MUX_LOCK_EN
            locked = lock[m_g] && req[m_g];
`endif
            if (locked) begin
                m_data = dsel(m_g);
            end else begin
                m_ptr = m_g;
                if (req != 4'd0) begin
                    m_g = rr_next(m_g);
                    m_data = dsel(m_g);
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic check_model(input string nm);
        int eg, ea;
        #1;
        eg = m_busy ? (1 << m_g) : 0;
        ea = (m_busy && out_ready && rst_n) ? (1 << m_g) : 0;
        cmp({nm, ".valid"}, int'(out_valid), int'(m_busy));
        cmp({nm, ".data"}, int'(out_data), m_data);
        cmp({nm, ".grant"}, int'(grant), eg);
        cmp({nm, ".ack"}, int'(ack), ea);
        cmp({nm, ".sel"}, int'({S1, S0}), m_g);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    int exp_lock_g[4];
    int got_g[4];

    initial begin
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0};
        tbl[1]  = '{1'b1, 4'h1, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0};
        tbl[2]  = '{1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h9, 4'h1, 4'h1, 2'd0};
        tbl[3]  = '{1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h9, 4'h0, 4'h0, 2'd0};
        tbl[4]  = '{1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 4'h9, 4'h0, 4'h0, 2'd0};
        tbl[5]  = '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0};
        tbl[6]  = '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 4'h1, 4'h1, 4'h1, 2'd0};
        tbl[7]  = '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 4'h2, 4'h2, 4'h2, 2'd1};
        tbl[8]  = '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 4'h3, 4'h4, 4'h4, 2'd2};
        tbl[9]  = '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 4'h4, 4'h8, 4'h8, 2'd3};
        tbl[10] = '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 4'h1, 4'h1, 4'h1, 2'd0};
        tbl[11] = '{1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 4'h2, 4'h2, 4'h2, 2'd1};
        tbl[12] = '{1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 4'h2, 4'h0, 4'h0, 2'd1};

        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        tick();

        // basic grant, hold and round-robin vectors
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst_n, tbl[i].req, tbl[i].a, tbl[i].b,
                  tbl[i].c, tbl[i].d, tbl[i].rdy, 4'h0);
            #1;
            cmp($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].ev));
            cmp($sformatf("tbl%0d.data", i), int'(out_data), int'(tbl[i].ed));
            cmp($sformatf("tbl%0d.grant", i), int'(grant), int'(tbl[i].eg));
            cmp($sformatf("tbl%0d.ack", i), int'(ack), int'(tbl[i].ea));
            cmp($sformatf("tbl%0d.sel", i), int'({S1, S0}), int'(tbl[i].es));
            tick();
        end

        // stall with changing data and requests
        drive(1'b1, 4'b0100, 4'h0, 4'h0, 4'h5, 4'hA, 1'b0, 4'h0);
        check_model("stall_req");
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1011, 4'h0, 4'h0, 4'h7, 4'hA, 1'b0, 4'h0);
            #1;
            cmp("stall.data", int'(out_data), 5);
            cmp("stall.grant", int'(grant), 4);
            cmp("stall.ack", int'(ack), 0);
            check_model("stall");
            tick();
        end
        drive(1'b1, 4'b1011, 4'h0, 4'h0, 4'h7, 4'hA, 1'b1, 4'h0);
        #1;
        cmp("stall_rel.ack", int'(ack), 4);
        tick();
        #1;
        cmp("stall_next.grant", int'(grant), 8);
        cmp("stall_next.data", int'(out_data), 10);

        // reset during a transfer cycle
        drive(1'b0, 4'b1011, 4'h0, 4'h0, 4'h7, 4'hA, 1'b1, 4'h0);
        #1;
        cmp("rst_xfer.ack", int'(ack), 0);
        cmp("rst_xfer.valid", int'(out_valid), 1);
        tick();
        drive(1'b1, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h6, 1'b0, 4'h0);
        #1;
        cmp("post_rst.all", int'({out_valid, out_data, grant, ack, S1, S0}), 0);
        tick();
        #1;
        cmp("post_rst.grant", int'(grant), 8);
        cmp("post_rst.data", int'(out_data), 6);

        // lock sequence: grants 0,0,0,1 with lock, 0,1,0,1 without
`ifdef RR_MUX_LOCK_EN
        exp_lock_g = '{0, 0, 0, 1};
`else
        exp_lock_g = '{0, 1, 0, 1};
`endif
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0011, 4'h1, 4'h2, 4'h0, 4'h0, 1'b1,
                  (i < 3) ? 4'b0001 : 4'b0000);
            check_model("lockseq");
            if (i > 0) got_g[i-1] = int'({S1, S0});
            tick();
        end
        for (int i = 0; i < 4; i++)
            cmp($sformatf("lockseq.g%0d", i), got_g[i], exp_lock_g[i]);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0), 4'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            check_model("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: DW, 4, data width of each requester input and of out_data.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 a, b, c, d  input  DW each  data of requesters 0, 1, 2, 3.
REQ-006 out_ready  input  1  downstream consumer can accept out_data this cycle.
REQ-007 lock  input  4  per-requester hold-grant request; present only when RR_MUX_LOCK_EN is defined.
REQ-008 out_valid  output  1  out_data holds a granted word.
REQ-009 out_data  output  DW  registered data of the granted requester.
REQ-010 grant  output  4  one-hot current grant; all-zero when idle.
REQ-011 ack  output  4  one-cycle pulse on bit g in the cycle requester g's word transfers.
REQ-012 S0, S1  output  1 each  registered select of the granted requester, encoded as {S1,S0} = g; drives a downstream 4:1 mux.

Function
REQ-013 FSM states: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 IDLE, any req bit set: pick the winner round-robin, starting at ptr+1 mod 4. At the next edge, enter BUSY with grant=onehot(g), {S1,S0}=g, and out_data=data of g.
REQ-015 Selection latency: 1 cycle from req sampled high in IDLE to out_valid=1.
REQ-016 BUSY with out_ready=0: out_data, grant, S0 and S1 stay unchanged; req changes are ignored.
REQ-017 Transfer: occurs in any cycle with out_valid=1 and out_ready=1. That cycle drives ack[g]=1, and ptr updates to g at the edge.
REQ-018 Transfer, other req bits set (req as sampled in the transfer cycle): re-arbitrate from g+1 with no bubble, stay in BUSY, and load the new winner's data.
REQ-019 Transfer, only req[g] set: regrant g, because it has lowest priority yet is the sole requester.
REQ-020 Transfer, req all zero: go to IDLE and clear grant. out_data holds its last value; S0 and S1 hold.
REQ-021 out_data is captured only at grant time. Requester data may change after grant without effect.
REQ-022 At most one ack bit is set per cycle. ack=0 in any cycle without a transfer.
REQ-023 Starvation bound (lock absent): a continuously requesting requester is granted within 4 transfers.

Reset
REQ-024 rst_n=0 at an edge: state=IDLE, ptr=3 (requester 0 has first priority), out_valid=0, out_data=0, grant=0, ack=0, S0=S1=0.
REQ-025 Reset asserted in BUSY discards the pending word with no ack. Reset dominates a simultaneous transfer.

Configuration
REQ-026 Macro RR_MUX_LOCK_EN defined:
- lock port exists.
- At a transfer with lock[g]=1 and req[g]=1, regrant g regardless of other requests.
- ptr is not advanced.
REQ-027 RR_MUX_LOCK_EN undefined: no lock port; pure round-robin per REQ-014 to REQ-020.

Structure
REQ-028 Package rr_mux_pkg holds: NREQ=4 constant, state enum (IDLE, BUSY), default DW.
REQ-029 Combinational sub-module rr_mux_pick: inputs req[3:0] and ptr[1:0]; outputs winner index[1:0] and any_req. Instantiated once.

Verification
REQ-030 Reset, then req=0001, a=4'h9, out_ready=1 -> cycle+1: out_valid=1, out_data=9, grant=0001, {S1,S0}=00. Same cycle: ack=0001. Next cycle: req=0, so IDLE.
REQ-031 req=1111 held, data a..d=1,2,3,4, out_ready=1 -> out_data sequence 1,2,3,4,1, one word per cycle, ack rotating 0001,0010,0100,1000.
REQ-032 Granted requester 2 (c=5), out_ready=0 for 3 cycles, c changed to 7, req=1011 -> out_data stays 5, grant 0100, ack=0. out_ready=1 -> ack=0100, then requester 3 granted.
REQ-033 rst_n=0 while out_valid=1 and out_ready=1 -> no ack. Next cycle all outputs zero. After release with req=1000, requester 3 is granted.
REQ-034 RR_MUX_LOCK_EN defined, req=0011, lock=0001 for 3 transfers, then lock=0 -> grants 0,0,0, then 1.
REQ-035 RR_MUX_LOCK_EN undefined, same stimulus -> grants alternate 0,1,0,1.
